// File: rtl/issue_fifo_multi.sv
// Superscalar in-order issue queue: up to WR_PORTS all-or-nothing enqueues and
// up to RD_PORTS prefix-ordered dequeues per cycle, with occupancy status flags.

module issue_fifo_rd_lane #(
    parameter int CW   = 5,
    parameter int LANE = 0
) (
    input  logic [CW-1:0] count,
    input  logic          rd_en,
    input  logic          prev_go,
    output logic          rd_valid,
    output logic          pop_go
);
    assign rd_valid = (count > CW'(LANE));
    // A lane pops only if every lower lane also pops, so pops stay a prefix.
    assign pop_go   = prev_go && rd_en && rd_valid;
endmodule

module issue_fifo_multi #(
    parameter int  DEPTH        = 16,
    parameter int  WR_PORTS     = 2,
    parameter int  RD_PORTS     = 2,
    parameter int  AFULL_THRESH = 12,
    parameter type RS_ENTRY_t   = logic [31:0],
    parameter int  CW           = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [WR_PORTS-1:0]            wr_en,
    input  RS_ENTRY_t [WR_PORTS-1:0]       wr_data,
    output logic                           wr_accept,
    output logic [RD_PORTS-1:0]            rd_valid,
    output RS_ENTRY_t [RD_PORTS-1:0]       rd_data,
    input  logic [RD_PORTS-1:0]            rd_en,
    output logic [CW-1:0]                  count,
    output logic [CW-1:0]                  free_slots,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           overflow_err
);
    localparam int PW = $clog2(DEPTH);

    RS_ENTRY_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   n_wr, n_rd;
    logic [RD_PORTS:0] go_chain;

    always_comb begin
        n_wr = '0;
        for (int i = 0; i < WR_PORTS; i++) n_wr = n_wr + CW'(wr_en[i]);
    end

    always_comb begin
        n_rd = '0;
        for (int i = 1; i <= RD_PORTS; i++) n_rd = n_rd + CW'(go_chain[i]);
    end

    assign free_slots  = CW'(DEPTH) - count;
    // Room is judged on start-of-cycle occupancy; same-cycle pops do not help.
    assign wr_accept   = (n_wr <= free_slots) && !flush;
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AFULL_THRESH));

    assign go_chain[0] = 1'b1;
    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        issue_fifo_rd_lane #(.CW(CW), .LANE(i)) u_lane (
            .count    (count),
            .rd_en    (rd_en[i]),
            .prev_go  (go_chain[i]),
            .rd_valid (rd_valid[i]),
            .pop_go   (go_chain[i+1])
        );
        assign rd_data[i] = mem[rd_ptr + PW'(i)];
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < WR_PORTS; i++)
                if (wr_en[i]) mem[wr_ptr + PW'(i)] <= wr_data[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + n_wr[PW-1:0];
            else if (n_wr != '0) overflow_err <= 1'b1;
            rd_ptr <= rd_ptr + n_rd[PW-1:0];
            count  <= count + (wr_accept ? n_wr : CW'(0)) - n_rd;
        end
    end
endmodule

// File: tb/tb_issue_fifo_multi.sv
// Directed bench for issue_fifo_multi; the stimulus side queues expected entries,
// a negedge monitor compares the read lanes and retires entries as they pop.

module tb_issue_fifo_multi;
    logic              clk = 0;
    logic              rst = 1;
    logic              flush = 0;
    logic [1:0]        wr_en = '0;
    logic [1:0][31:0]  wr_data = '0;
    logic              wr_accept;
    logic [1:0]        rd_valid;
    logic [1:0][31:0]  rd_data;
    logic [1:0]        rd_en = '0;
    logic [4:0]        count, free_slots;
    logic              full, empty, almost_full, overflow_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];

    issue_fifo_multi dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .wr_accept(wr_accept),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_en(rd_en),
        .count(count), .free_slots(free_slots), .full(full), .empty(empty),
        .almost_full(almost_full), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst) assert (wr_en != 2'b10) else $error("non-prefix wr_en");

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; returns #1 after the active edge with inputs idled.
    task automatic step(input logic [1:0] we, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] re, input logic fl, input logic exp_acc);
        wr_en = we; wr_data[0] = d0; wr_data[1] = d1; rd_en = re; flush = fl;
        if (exp_acc) begin
            if (we[0]) pend_q.push_back(d0);
            if (we[1]) pend_q.push_back(d1);
        end
        @(negedge clk);
        chk("wr_accept", wr_accept, exp_acc);
        @(posedge clk); #1;
        wr_en = '0; rd_en = '0; flush = 0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                int n;
                logic go;
                chk("count_vs_model", count, exp_q.size());
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("rd_valid[%0d]", i), rd_valid[i], exp_q.size() > i);
                    if (exp_q.size() > i) chk($sformatf("rd_data[%0d]", i), rd_data[i], exp_q[i]);
                end
                if (flush) begin
                    exp_q.delete();
                    pend_q.delete();
                end else begin
                    n = 0; go = 1;
                    for (int i = 0; i < 2; i++) begin
                        go = go && rd_en[i] && (exp_q.size() > i);
                        if (go) n++;
                    end
                    repeat (n) void'(exp_q.pop_front());
                    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
                end
            end
        end
    end

    initial begin : stim
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_free", free_slots, 16);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_ovf", overflow_err, 0);
        #1 rst = 0;
        @(posedge clk); #1;

        // A,B enqueue as a pair
        step(2'b11, 32'hA, 32'hB, 2'b00, 0, 1);
        chk("t1_count", count, 2);
        chk("t1_rd_valid", rd_valid, 2'b11);
        chk("t1_free", free_slots, 14);

        // fill to 15, then a 2-wide group must be rejected even with a pop
        for (int k = 0; k < 6; k++) step(2'b11, 32'h100 + 2*k, 32'h101 + 2*k, 2'b00, 0, 1);
        step(2'b01, 32'h10C, 32'h0, 2'b00, 0, 1);
        chk("t2_count15", count, 15);
        chk("t2_full15", full, 0);
        chk("t2_afull15", almost_full, 1);
        chk("t2_free15", free_slots, 1);
        step(2'b11, 32'hE0, 32'hE1, 2'b01, 0, 0);
        chk("t2_count14", count, 14);
        chk("t2_ovf", overflow_err, 1);
        repeat (10) step(2'b00, 32'h0, 32'h0, 2'b00, 0, 1);
        chk("t2_ovf_sticky", overflow_err, 1);

        // drain; both pointers end at 15
        repeat (7) step(2'b00, 32'h0, 32'h0, 2'b11, 0, 1);
        chk("t3_drain_count", count, 0);
        chk("t3_drain_empty", empty, 1);

        // wrap-around write and read
        step(2'b11, 32'hC1, 32'hC2, 2'b00, 0, 1);
        chk("t3_slot15", dut.mem[15], 32'hC1);
        chk("t3_slot0", dut.mem[0], 32'hC2);
        step(2'b00, 32'h0, 32'h0, 2'b11, 0, 1);
        chk("t3_count", count, 0);
        chk("t3_empty", empty, 1);

        // almost_full threshold edges, then completely full
        for (int k = 0; k < 5; k++) step(2'b11, 32'h200 + 2*k, 32'h201 + 2*k, 2'b00, 0, 1);
        step(2'b01, 32'h20A, 32'h0, 2'b00, 0, 1);
        chk("t4_count11", count, 11);
        chk("t4_afull11", almost_full, 0);
        step(2'b01, 32'h20B, 32'h0, 2'b00, 0, 1);
        chk("t4_afull12", almost_full, 1);
        step(2'b00, 32'h0, 32'h0, 2'b11, 0, 1);
        chk("t4_count10", count, 10);
        chk("t4_afull10", almost_full, 0);
        for (int k = 0; k < 3; k++) step(2'b11, 32'h300 + 2*k, 32'h301 + 2*k, 2'b00, 0, 1);
        chk("t4_full", full, 1);
        chk("t4_free0", free_slots, 0);
        step(2'b01, 32'hF0, 32'h0, 2'b00, 0, 0);
        chk("t4_full_hold", count, 16);

        // flush wins over simultaneous enqueue and dequeue
        repeat (5) step(2'b00, 32'h0, 32'h0, 2'b11, 0, 1);
        step(2'b00, 32'h0, 32'h0, 2'b01, 0, 1);
        chk("t5_count5", count, 5);
        step(2'b11, 32'hD0, 32'hD1, 2'b11, 1, 0);
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_rd_valid", rd_valid, 0);
        step(2'b11, 32'h50, 32'h51, 2'b00, 0, 1);
        chk("t5_slot0", dut.mem[0], 32'h50);
        chk("t5_count2", count, 2);

        // non-prefix pop, then a real pop, then async reset mid-burst
        step(2'b01, 32'h52, 32'h0, 2'b00, 0, 1);
        step(2'b00, 32'h0, 32'h0, 2'b10, 0, 1);
        chk("t6_gap_count", count, 3);
        step(2'b00, 32'h0, 32'h0, 2'b11, 0, 1);
        chk("t6_count1", count, 1);
        wr_en = 2'b11; wr_data[0] = 32'h60; wr_data[1] = 32'h61;
        #2 rst = 1;
        #1;
        chk("t6_async_count", count, 0);
        chk("t6_async_empty", empty, 1);
        exp_q.delete();
        pend_q.delete();
        wr_en = '0;
        @(negedge clk); #1 rst = 0;
        @(posedge clk); #1;
        step(2'b01, 32'h70, 32'h0, 2'b00, 0, 1);
        chk("t6_slot0", dut.mem[0], 32'h70);
        chk("t6_count_after", count, 1);
        step(2'b00, 32'h0, 32'h0, 2'b01, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_fifo_multi.md
Name: issue_fifo_multi

Overview:
- Superscalar, in-order issue queue holding RS_ENTRY_t entries.
- Accepts up to WR_PORTS entries and dispatches up to RD_PORTS entries per cycle.
- Sits between rename/dispatch and the execution-unit issue stage, in place of the single-port issue FIFO.
- Adds several new features over the single-port FIFO:
  - group (all-or-nothing) enqueue;
  - prefix-ordered multi-dequeue;
  - exposed occupancy and free count;
  - programmable almost-full threshold;
  - a sticky overflow error flag.

Parameters:
DEPTH, 16, entry count; power of two, >= max(WR_PORTS, RD_PORTS).
WR_PORTS, 2, enqueue lanes per cycle (1..4).
RD_PORTS, 2, dequeue lanes per cycle (1..4).
AFULL_THRESH, 12, almost_full asserts when count >= this value (1..DEPTH).
CW, $clog2(DEPTH)+1, width of the count fields (derived; do not override).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous squash of all contents.
wr_en  in  WR_PORTS  per-lane enqueue request; must be a contiguous prefix (lane 0 upward).
wr_data  in  WR_PORTS x RS_ENTRY_t  enqueue payload; lane i is younger than lane i-1.
wr_accept  out  1  combinational; high when the whole wr_en group fits this cycle.
rd_valid  out  RD_PORTS  rd_valid[i] = (count > i).
rd_data  out  RD_PORTS x RS_ENTRY_t  rd_data[i] = mem[(rd_ptr+i) mod DEPTH]; combinational from stored state.
rd_en  in  RD_PORTS  per-lane pop request.
count  out  CW  current occupancy, 0..DEPTH.
free_slots  out  CW  DEPTH - count.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AFULL_THRESH.
overflow_err  out  1  sticky flag; set when wr_en != 0 and wr_accept == 0.

Behaviour:
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, count=0, overflow_err=0. Outputs therefore read empty=1, full=0, almost_full=0, free_slots=DEPTH, rd_valid=0. Memory contents are not reset.
- Reset mid-operation discards all entries; first enqueue after release lands at slot 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy comes only from count, never from pointer comparison.
- Enqueue:
  - n_wr = popcount(wr_en).
  - wr_accept = (n_wr <= free_slots) && !flush, where free_slots is the start-of-cycle value; pops in the same cycle do not create room.
  - If accepted, lane i writes mem[(wr_ptr+i) mod DEPTH] and wr_ptr += n_wr.
  - If not accepted, no lane is written (all-or-nothing), wr_ptr is unchanged, and overflow_err is set if n_wr > 0.
- Dequeue:
  - Effective pop lane i = rd_en[i] && rd_valid[i] && all lower lanes popping.
  - n_rd = number of effective pops; rd_ptr += n_rd.
  - A non-prefix rd_en (e.g. 2'b10) pops nothing for the gap lane and above.
- Simultaneous enqueue and dequeue: count_next = count + (accepted ? n_wr : 0) - n_rd. No write-to-read bypass; an entry is visible on rd_data the cycle after it is written.
- Wrap-around: a group write or read straddling slot DEPTH-1 to slot 0 is legal and must preserve order.
- Flush: takes priority over wr_en and rd_en. Next cycle: wr_ptr=0, rd_ptr=0, count=0. overflow_err is unaffected; only rst clears it.
- Flush and rst in the same cycle: rst wins (identical state).
- Non-prefix wr_en is illegal input. The bench asserts it never happens; RTL behaviour for it is undefined.
- Latency: enqueue to rd_valid = 1 cycle. Pop to next entry on rd_data = 1 cycle.

Test Plan:
- Reset, then enqueue A,B (wr_en=2'b11) -> next cycle count=2, rd_valid=2'b11, rd_data[0]=A, rd_data[1]=B, free_slots=14.
- Fill to 15 entries, then request 2 (wr_en=2'b11) while popping 1 -> wr_accept=0, count=14, overflow_err=1 and still 1 after 10 idle cycles.
- Pointers at 15, enqueue X,Y -> X in slot 15, Y in slot 0. Pop both -> read order X then Y, count=0, empty=1.
- count=11, enqueue 1 -> almost_full=1 at count=12. Pop 2 -> almost_full=0 at count=10.
- count=5 with flush=1, wr_en=2'b11, rd_en=2'b11 -> next cycle count=0, empty=1, no entries written. Next enqueue lands at slot 0.
- count=3, rd_en=2'b10 -> nothing popped, count=3. Then rd_en=2'b11 -> count=1. Assert rst asynchronously mid-burst -> count=0 and empty=1 before the next clock edge.
